// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, x/y counters, sync-aligned colour
// output stage and a frame-synchronous robot step strobe.
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int STEP_FRAMES = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        step_en,
  input  logic [23:0] rgb_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        robot_step,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [7:0] STEP_COUNT = 8'(STEP_FRAMES);

  logic       div;
  logic       x_last;
  logic       y_last;
  logic       frame_wrap;
  logic       hsync_win;
  logic       vsync_win;
  logic [7:0] frame_cnt;
  logic [7:0] frame_inc;

  assign pix_tick   = div;
  assign VGA_CLK    = div;
  assign VGA_SYNC_N = 1'b0;

  assign x_last     = (pixel_x == H_LAST);
  assign y_last     = (pixel_y == V_LAST);
  assign frame_wrap = div & x_last & y_last;

  assign video_on  = (pixel_x < H_VIS_END) && (pixel_y < V_VIS_END);
  assign hsync_win = (pixel_x >= HS_START) && (pixel_x < HS_END);
  assign vsync_win = (pixel_y >= VS_START) && (pixel_y < VS_END);

  // Frame counter saturates at STEP_FRAMES so a held-off step fires on the next frame.
  always_comb begin
    frame_inc = frame_cnt;
    if (frame_cnt >= STEP_COUNT) begin
      frame_inc = STEP_COUNT;
    end else begin
      frame_inc = frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div <= 1'b0;
    end else begin
      div <= ~div;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pixel_x <= 10'd0;
      pixel_y <= 10'd0;
    end else if (div) begin
      if (x_last) begin
        pixel_x <= 10'd0;
        pixel_y <= y_last ? 10'd0 : pixel_y + 10'd1;
      end else begin
        pixel_x <= pixel_x + 10'd1;
      end
    end
  end

  // Pins sample the pre-increment counters, so sync and colour share one tick of latency.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
    end else if (div) begin
      VGA_HS      <= ~hsync_win;
      VGA_VS      <= ~vsync_win;
      VGA_BLANK_N <= video_on;
      VGA_R       <= video_on ? rgb_in[23:16] : 8'd0;
      VGA_G       <= video_on ? rgb_in[15:8]  : 8'd0;
      VGA_B       <= video_on ? rgb_in[7:0]   : 8'd0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_start <= 1'b0;
      robot_step  <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_start <= frame_wrap;
      robot_step  <= 1'b0;
      if (frame_wrap) begin
        if ((frame_inc == STEP_COUNT) && step_en) begin
          robot_step <= 1'b1;
          frame_cnt  <= 8'd0;
        end else begin
          frame_cnt <= frame_inc;
        end
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA timing from the 50 MHz board clock, exposes the raster position to the maze/robot renderer, and registers the renderer's colour back onto the VGA pins with matched sync delay. It also emits a frame-synchronous `robot_step` strobe so the robot FSM advances exactly once per N displayed frames, never mid-frame. It sits between `CLOCK_50` and the VGA DAC pins in `top`, directly upstream of the renderer (`world`).

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48 (line total 800)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33 (frame total 525)
- `STEP_FRAMES`, 1, frames per `robot_step` pulse (1..255)

Ports:
- `CLOCK_50`  in  1  50 MHz system clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `step_en`  in  1  enables `robot_step` generation
- `rgb_in`  in  24  renderer colour {R,G,B} for current `pixel_x`/`pixel_y`, combinational from them
- `pixel_x`  out  10  horizontal counter, 0..799
- `pixel_y`  out  10  vertical counter, 0..524
- `video_on`  out  1  high when `pixel_x`<640 and `pixel_y`<480 (combinational from counters)
- `pix_tick`  out  1  one-`CLOCK_50` pixel enable (25 MHz rate)
- `frame_start`  out  1  one-cycle pulse when counters wrap to (0,0)
- `robot_step`  out  1  one-cycle pulse, see Operation
- `VGA_CLK`  out  1  25 MHz pixel clock to DAC
- `VGA_HS`, `VGA_VS`  out  1 each  active-low syncs
- `VGA_BLANK_N`  out  1  low outside visible area
- `VGA_SYNC_N`  out  1  constant 0
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  registered colour, 0 when blanked

## Operation
- Divider: 1-bit `div` reset to 0, toggles every cycle; `pix_tick` = (`div`==1). `VGA_CLK` = `div`.
- On `pix_tick`: `pixel_x` increments; at 799 wraps to 0 and `pixel_y` increments; `pixel_y` at 524 with `pixel_x` 799 wraps to 0. No change on non-tick cycles.
- Sync windows (counter domain): HS low for `pixel_x` in 656..751; VS low for `pixel_y` in 490..491.
- Output stage (registered on `pix_tick`, from pre-increment counters): `VGA_HS`, `VGA_VS`, `VGA_BLANK_N` = `video_on`, and `VGA_R/G/B` = `rgb_in` if `video_on` else 0. Sync and colour therefore stay aligned.
- `frame_start` asserted in the cycle after the tick that produced (0,0).
- Frame counter (8 bit) increments on each `frame_start`; when it reaches `STEP_FRAMES` and `step_en`=1, `robot_step` pulses in that same cycle and the counter clears. With `step_en`=0 the counter holds at `STEP_FRAMES` (saturates) and the pulse fires on the first `frame_start` after `step_en` rises.
- Pixel/frame arithmetic is unsigned, no overflow beyond stated wraps.

## Timing
- Reset (any cycle, including mid-line): next cycle `div`=0, counters (0,0), frame counter 0; `VGA_HS`=`VGA_VS`=1, `VGA_BLANK_N`=0, RGB=0, `frame_start`=`robot_step`=0, `VGA_SYNC_N`=0. Reset overrides a coincident tick.
- First `pix_tick` is the 2nd cycle after reset release; ticks every 2 cycles thereafter.
- Counter-to-pin latency: exactly one pixel tick (2 `CLOCK_50` cycles).
- Line = 1600 cycles; frame = 840 000 cycles (16.8 ms).
- `robot_step` and `frame_start` are exactly one `CLOCK_50` cycle wide and never coincide with a visible pixel.

## Test plan
- Reset then run 1602 cycles -> `pixel_x` returns to 0 with `pixel_y`=1; `pix_tick` seen 801 times; `VGA_HS` low for exactly 192 cycles, starting 2 cycles after `pixel_x` becomes 656.
- Run one frame -> `frame_start` single pulse at cycle 840 000 (relative to first tick alignment); `VGA_VS` low for 3200 cycles; test harness observing `pixel_y`==480,`pixel_x`==0 sees it once per frame.
- `rgb_in`=24'hFF8040 constant -> pins read (255,128,64) at visible pixels and (0,0,0) with `VGA_BLANK_N`=0 at `pixel_x`=640..799 and `pixel_y`≥480.
- `STEP_FRAMES`=3, `step_en`=1 for 7 frames -> `robot_step` at frames 3 and 6 only; drop `step_en` during frames 7-9, raise at frame 10 -> pulse at next `frame_start`.
- Assert `reset` for one cycle at `pixel_x`=300,`pixel_y`=200 -> next cycle counters (0,0), all outputs at reset values, timing restarts identically to power-up.
- Reset coincident with `pix_tick` -> no increment; counters stay (0,0).
